// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory path: word width, mem_port state
// encoding and the default access timeout.
package mips_pkg;

   localparam int unsigned WORD_W              = 32;
   localparam int unsigned MEM_TIMEOUT_DEFAULT = 255;

   typedef enum logic [1:0] {
      MP_IDLE = 2'd0,
      MP_REQ  = 2'd1,
      MP_DONE = 2'd2
   } mp_state_e;

   function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
      return {addr[WORD_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts REQ-state cycles; expired is high during the CYCLES-th counted cycle.
// Used by mem_port only when MEM_TIMEOUT_EN is defined.
module mem_timeout_ctr #(
   parameter int unsigned CYCLES = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CNT_W = $clog2(CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;

   assign expired = (cnt_q == CNT_W'(CYCLES - 1));

   // Saturating cycle counter, restarted on every new access.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && !expired) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end else begin
         cnt_q <= cnt_q;
      end
   end

endmodule

// File: rtl/mem_port.sv
// Multi-cycle memory port between the control unit and a ready-handshaked memory.
// Optional access timeout with sticky mem_err under `define MEM_TIMEOUT_EN.
module mem_port
   import mips_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = MEM_TIMEOUT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              IorD,
   input  logic              MemWrite,
   input  logic              IRWrite,
   input  logic [WORD_W-1:0] pc,
   input  logic [WORD_W-1:0] alu_out,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] mem_addr,
   output logic [WORD_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_req,
   input  logic              mem_ready,
   input  logic [WORD_W-1:0] mem_rdata,
   output logic [WORD_W-1:0] instr,
   output logic [WORD_W-1:0] data,
   output logic              stall,
   output logic              mem_err
);

   mp_state_e         state_q;
   logic [WORD_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic [WORD_W-1:0] instr_q;
   logic [WORD_W-1:0] data_q;
   logic              fetch_q;
   logic              we_q;
   logic              req_q;

   logic              acc_s;
   logic              expired_s;
   logic [WORD_W-1:0] addr_d;
   logic              fetch_d;
   logic              we_d;

   // Access decode; a simultaneous fetch wins over a data access and never writes.
   always_comb begin
      acc_s   = IRWrite | IorD;
      fetch_d = IRWrite;
      we_d    = MemWrite & IorD & ~IRWrite;
      addr_d  = word_align((IorD && !IRWrite) ? alu_out : pc);
   end

   // Access FSM with the captured request and the instruction/data registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= MP_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         instr_q <= '0;
         data_q  <= '0;
         fetch_q <= 1'b0;
         we_q    <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         case (state_q)
            MP_IDLE: begin
               if (acc_s) begin
                  state_q <= MP_REQ;
                  req_q   <= 1'b1;
                  addr_q  <= addr_d;
                  fetch_q <= fetch_d;
                  we_q    <= we_d;
                  wdata_q <= wdata;
               end else begin
                  state_q <= MP_IDLE;
               end
            end
            MP_REQ: begin
               if (mem_ready) begin
                  state_q <= MP_DONE;
                  req_q   <= 1'b0;
                  if (!we_q) begin
                     if (fetch_q) begin
                        instr_q <= mem_rdata;
                     end else begin
                        data_q  <= mem_rdata;
                     end
                  end else begin
                     instr_q <= instr_q;
                  end
               end else if (expired_s) begin
                  state_q <= MP_DONE;
                  req_q   <= 1'b0;
               end else begin
                  state_q <= MP_REQ;
               end
            end
            MP_DONE: begin
               state_q <= MP_IDLE;
               req_q   <= 1'b0;
            end
            default: begin
               state_q <= MP_IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   // The control unit may only advance in the DONE cycle of an access.
   assign stall     = acc_s & (state_q != MP_DONE);
   assign mem_req   = req_q;
   assign mem_we    = we_q & req_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign instr     = instr_q;
   assign data      = data_q;

`ifdef MEM_TIMEOUT_EN
   logic err_q;
   logic ctr_clr_s;
   logic ctr_en_s;

   assign ctr_clr_s = (state_q == MP_IDLE) & acc_s;
   assign ctr_en_s  = (state_q == MP_REQ);

   mem_timeout_ctr #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout_ctr (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (ctr_clr_s),
      .en      (ctr_en_s),
      .expired (expired_s)
   );

   // Sticky abort flag, cleared only by reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         err_q <= 1'b0;
      end else if ((state_q == MP_REQ) && !mem_ready && expired_s) begin
         err_q <= 1'b1;
      end else begin
         err_q <= err_q;
      end
   end

   assign mem_err = err_q;
`else
   assign expired_s = 1'b0;
   assign mem_err   = 1'b0;
`endif

endmodule

// File: doc/mem_port.md
MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 The parameters SHALL be:
  - TIMEOUT_CYCLES, default 255: REQ-state cycles before abort; used only with MEM_TIMEOUT_EN.
REQ-002 The ports SHALL be, in this order:
  - clk  in  1  rising-edge clock.
  - rst_n  in  1  reset, active-low.
  - IorD  in  1  address select: 1 = alu_out (data access), 0 = pc.
  - MemWrite  in  1  write request, honoured only when IorD=1.
  - IRWrite  in  1  instruction-fetch request.
  - pc  in  32  fetch address.
  - alu_out  in  32  data address.
  - wdata  in  32  store data.
  - mem_addr  out  32  word address to memory, bits[1:0]=0.
  - mem_wdata  out  32  store data to memory.
  - mem_we  out  1  write strobe, qualified by mem_req.
  - mem_req  out  1  request valid.
  - mem_ready  in  1  memory accepts the request, and read data is valid, this cycle.
  - mem_rdata  in  32  read data.
  - instr  out  32  instruction register.
  - data  out  32  memory data register.
  - stall  out  1  holds the control-unit state register while high.
  - mem_err  out  1  sticky timeout flag.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low, with ports named clk and rst_n.

Function
REQ-004 An access request (acc) SHALL be IRWrite | IorD.
REQ-005 The FSM SHALL have states IDLE, REQ and DONE.
  - IDLE -> REQ on acc.
  - REQ -> DONE on mem_ready.
  - DONE -> IDLE unconditionally.
REQ-006 On the IDLE->REQ edge, the block SHALL capture the following into internal registers and hold them unchanged through REQ:
  - address: alu_out if IorD else pc, bits[1:0] cleared.
  - kind: fetch if IRWrite else data.
  - write: MemWrite & IorD & ~IRWrite.
  - wdata.
REQ-007 If IRWrite and IorD are both 1, the access SHALL be a fetch from pc (IRWrite priority) and SHALL perform no write.
REQ-008 mem_req SHALL be 1 exactly while in REQ, with mem_addr, mem_we and mem_wdata driven from the captured registers.
REQ-009 On a REQ cycle with mem_ready=1 and a read access, mem_rdata SHALL be loaded into instr (fetch) or data (data read) at that edge; the other register is unchanged.
REQ-010 A write access SHALL leave instr and data unchanged.
REQ-011 stall SHALL be combinational and equal to acc & (state != DONE).
  - The control unit advances only in the DONE cycle.
  - Minimum latency is 3 cycles (acc cycle, REQ with ready, DONE), with stall high for 2 of them.
REQ-012 mem_ready while in IDLE or DONE SHALL be ignored.
REQ-013 mem_rdata SHALL be sampled only on REQ & mem_ready.
REQ-014 If acc=0 in IDLE, the block SHALL stay in IDLE with stall=0 and mem_req=0.
REQ-015 Back-to-back requests SHALL pass through IDLE for one cycle between DONE and the next REQ.

Reset
REQ-016 While rst_n=0 at a clock edge, the block SHALL:
  - go to state IDLE.
  - clear instr, data, mem_err and the captured address/data registers to 0.
REQ-017 Reset asserted during REQ SHALL abort the access, with mem_req=0 from the following cycle and no register load.
REQ-018 After reset, the outputs SHALL be:
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_err=0.
  - stall = acc.

Configuration
REQ-019 With MEM_TIMEOUT_EN defined, the block SHALL include a REQ-cycle counter, cleared on entry to REQ.
  - When it reaches TIMEOUT_CYCLES without mem_ready, the FSM goes to DONE and mem_err is set.
  - instr and data are not updated by the aborted access.
  - mem_err holds until reset.
REQ-020 Without MEM_TIMEOUT_EN, REQ SHALL wait indefinitely for mem_ready, mem_err SHALL be constant 0, and no counter logic SHALL exist.

Structure
REQ-021 The shared package mips_pkg SHALL hold:
  - the mem_port state encoding.
  - the word width (32).
  - the TIMEOUT_CYCLES default.
REQ-022 The timeout counter SHALL be a sub-module mem_timeout_ctr (clk, rst_n, clr, en, expired), instantiated only under MEM_TIMEOUT_EN.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
  - Fetch, zero wait: IRWrite=1, pc=0x40, mem_ready=1 in the first REQ cycle, mem_rdata=0x8C010004 -> mem_addr=0x40 and mem_we=0 during REQ; instr=0x8C010004 in DONE; stall high for exactly 2 cycles.
  - Load, 3 wait states: IorD=1, alu_out=0x107 -> mem_addr=0x104 for 4 REQ cycles; data loaded on the ready cycle; instr unchanged.
  - Store: IorD=1, MemWrite=1, wdata=0xDEADBEEF -> mem_we=1 and mem_wdata=0xDEADBEEF during REQ; instr and data unchanged.
  - Conflict: IRWrite=1, IorD=1, MemWrite=1 -> mem_addr=pc, mem_we=0, instr loaded.
  - Reset mid-REQ: rst_n=0 in the 2nd wait cycle -> mem_req=0 next cycle; state IDLE; instr=0, data=0.
  - MEM_TIMEOUT_EN with TIMEOUT_CYCLES=4 and mem_ready held 0 -> DONE after 4 REQ cycles; mem_err=1 and sticky; instr unchanged.
